// File: rtl/rect_pkg.sv
// Shared encodings and default geometry for the rectangle-fill scheduler.
package rect_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_XW       = 8;
  localparam int DEF_YW       = 7;
  localparam int DEF_CW       = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_sched_rr_arbiter.sv
// Round-robin picker: first asserted request after last_grant, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any_grant
);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_grant) + k) % N_REQ;
      cand_idx = IW'(cand);
      if (!any_grant && req[cand_idx]) begin
        any_grant       = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_sched.sv
// Arbitrates rectangle-fill requests and walks the granted rectangle one pixel
// per cycle in row-major order, clipping pixels that fall off screen.
module rect_sched
  import rect_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int CW       = DEF_CW,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*XW-1:0] req_x,
  input  logic [N_REQ*YW-1:0] req_y,
  input  logic [N_REQ*XW-1:0] req_w,
  input  logic [N_REQ*YW-1:0] req_h,
  input  logic [N_REQ*CW-1:0] req_colour,
  output logic [N_REQ-1:0]    ack,
  output logic                busy,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [CW-1:0]       vga_colour,
  output logic                vga_plot
);

  localparam int IW = idx_width(N_REQ);
  localparam logic [XW:0] SCR_W = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] SCR_H = (YW+1)'(SCREEN_H);

  state_e           state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [XW-1:0]    x_q, x_d, w_q, w_d, dx_q, dx_d;
  logic [YW-1:0]    y_q, y_d, h_q, h_d, dy_q, dy_d;
  logic [CW-1:0]    colour_q, colour_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  logic [XW-1:0]    sel_x, sel_w;
  logic [YW-1:0]    sel_y, sel_h;
  logic [CW-1:0]    sel_colour;

  logic [XW:0]      sum_x;
  logic [YW:0]      sum_y;
  logic             drawing, on_screen, last_col, last_row;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req        (req),
    .last_grant (last_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_grant  (arb_any)
  );

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_w      = '0;
    sel_h      = '0;
    sel_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_x      = req_x[i*XW +: XW];
        sel_y      = req_y[i*YW +: YW];
        sel_w      = req_w[i*XW +: XW];
        sel_h      = req_h[i*YW +: YW];
        sel_colour = req_colour[i*CW +: CW];
      end
    end
  end

  // One extra bit so rectangles that run past the edge are clipped, not wrapped.
  assign sum_x     = {1'b0, x_q} + {1'b0, dx_q};
  assign sum_y     = {1'b0, y_q} + {1'b0, dy_q};
  assign drawing   = (state_q == S_DRAW);
  assign on_screen = (sum_x < SCR_W) && (sum_y < SCR_H);
  assign last_col  = (dx_q == w_q - XW'(1));
  assign last_row  = (dy_q == h_q - YW'(1));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    gnt_oh_d = gnt_oh_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    colour_d = colour_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          state_d  = S_GRANT;
          gnt_d    = arb_idx;
          gnt_oh_d = arb_grant;
          x_d      = sel_x;
          y_d      = sel_y;
          w_d      = sel_w;
          h_d      = sel_h;
          colour_d = sel_colour;
          dx_d     = '0;
          dy_d     = '0;
        end
      end
      S_GRANT: begin
        state_d = (w_q == '0 || h_q == '0) ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        if (last_col) begin
          dx_d = '0;
          if (last_row) state_d = S_DONE;
          else          dy_d    = dy_q + YW'(1);
        end else begin
          dx_d = dx_q + XW'(1);
        end
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      last_q   <= IW'(N_REQ-1);
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      colour_q <= colour_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
    end
  end

  // Outputs decode straight off the state register so reset silences them at once.
  assign busy       = (state_q != S_IDLE);
  assign ack        = (state_q == S_DONE) ? gnt_oh_q : '0;
  assign vga_x      = drawing ? sum_x[XW-1:0] : '0;
  assign vga_y      = drawing ? sum_y[YW-1:0] : '0;
  assign vga_colour = drawing ? colour_q : '0;
  assign vga_plot   = drawing && on_screen;

endmodule

// File: tb/tb_rect_sched.sv
// Directed bench for rect_sched: expected pixels/acks (with cycle stamps) are
// queued by the driver and popped by an independent negedge monitor.
module tb_rect_sched;
  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int TW = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*XW-1:0]   req_x = '0;
  logic [N*YW-1:0]   req_y = '0;
  logic [N*XW-1:0]   req_w = '0;
  logic [N*YW-1:0]   req_h = '0;
  logic [N*CW-1:0]   req_colour = '0;
  logic [N-1:0]      ack;
  logic              busy;
  logic [XW-1:0]     vga_x;
  logic [YW-1:0]     vga_y;
  logic [CW-1:0]     vga_colour;
  logic              vga_plot;

  logic [TW-1:0]           cyc = '0;
  logic [TW+XW+YW+CW-1:0]  pix_exp_q[$];
  logic [TW+N-1:0]         ack_exp_q[$];
  logic [TW+XW+YW+CW-1:0]  pix_e;
  logic [TW+N-1:0]         ack_e;
  int checks = 0;
  int errors = 0;
  int t;

  rect_sched dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .ack        (ack),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_params(input int i, input int x, input int y, input int w,
                            input int h, input int c);
    req_x[i*XW +: XW]      = XW'(x);
    req_y[i*YW +: YW]      = YW'(y);
    req_w[i*XW +: XW]      = XW'(w);
    req_h[i*YW +: YW]      = YW'(h);
    req_colour[i*CW +: CW] = CW'(c);
  endtask

  task automatic exp_pix(input int tc, input int x, input int y, input int c);
    pix_exp_q.push_back({TW'(tc), XW'(x), YW'(y), CW'(c)});
  endtask

  task automatic exp_ack(input int tc, input int i);
    ack_exp_q.push_back({TW'(tc), N'(1 << i)});
  endtask

  task automatic exp_rect(input int t0, input int x, input int y, input int w,
                          input int h, input int c);
    for (int dy = 0; dy < h; dy++)
      for (int dx = 0; dx < w; dx++)
        exp_pix(t0 + dy*w + dx, x + dx, y + dy, c);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pix_exp_q.size() != 0 || ack_exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pix_exp_q.size() != 0 || ack_exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pixels/%0d acks outstanding, expected 0",
               pix_exp_q.size(), ack_exp_q.size());
      pix_exp_q.delete();
      ack_exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // scoreboard monitor; also plays the requester side by dropping req on ack
  always @(negedge clk) begin
    if (vga_plot) begin
      check("busy_during_plot", 64'(busy), 64'd1);
      if (pix_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got (%0d,%0d) colour %0d at cycle %0d, expected none",
                 vga_x, vga_y, vga_colour, cyc);
      end else begin
        pix_e = pix_exp_q.pop_front();
        check("pixel", 64'({cyc, vga_x, vga_y, vga_colour}), 64'(pix_e));
      end
    end
    if (ack != '0) begin
      if (ack_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %b at cycle %0d, expected none", ack, cyc);
      end else begin
        ack_e = ack_exp_q.pop_front();
        check("ack", 64'({cyc, ack}), 64'(ack_e));
      end
      req = req & ~ack;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack",    64'(ack),        64'd0);
    check("reset_busy",   64'(busy),       64'd0);
    check("reset_plot",   64'(vga_plot),   64'd0);
    check("reset_x",      64'(vga_x),      64'd0);
    check("reset_y",      64'(vga_y),      64'd0);
    check("reset_colour", 64'(vga_colour), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // round-robin order 0,1,2,3,0 with req0 reasserted after its first ack
    @(negedge clk);
    for (int i = 0; i < N; i++) set_params(i, i, i, 1, 1, i);
    req = 4'b1111;
    t = int'(cyc);
    exp_pix(t+2, 0, 0, 0);  exp_ack(t+3, 0);
    exp_pix(t+6, 1, 1, 1);  exp_ack(t+7, 1);
    exp_pix(t+10, 2, 2, 2); exp_ack(t+11, 2);
    exp_pix(t+14, 3, 3, 3); exp_ack(t+15, 3);
    exp_pix(t+18, 0, 0, 0); exp_ack(t+19, 0);
    repeat (4) @(negedge clk);
    req[0] = 1'b1;
    drain(100);

    // basic 3x2 fill
    @(negedge clk);
    set_params(0, 10, 20, 3, 2, 5);
    req = 4'b0001;
    t = int'(cyc);
    exp_rect(t+2, 10, 20, 3, 2, 5);
    exp_ack(t+8, 0);
    drain(100);

    // zero width: no pixels, ack two cycles after sampling
    @(negedge clk);
    set_params(2, 30, 40, 0, 4, 6);
    req = 4'b0100;
    t = int'(cyc);
    exp_ack(t+2, 2);
    drain(100);

    // clipping at the bottom-right corner
    @(negedge clk);
    set_params(1, 158, 119, 4, 2, 7);
    req = 4'b0010;
    t = int'(cyc);
    exp_pix(t+2, 158, 119, 7);
    exp_pix(t+3, 159, 119, 7);
    exp_ack(t+10, 1);
    drain(100);

    // request arriving mid-draw waits its turn
    @(negedge clk);
    set_params(0, 5, 6, 3, 2, 1);
    set_params(3, 50, 60, 2, 1, 3);
    req = 4'b0001;
    t = int'(cyc);
    exp_rect(t+2, 5, 6, 3, 2, 1);
    exp_ack(t+8, 0);
    exp_rect(t+11, 50, 60, 2, 1, 3);
    exp_ack(t+13, 3);
    repeat (4) @(negedge clk);
    req[3] = 1'b1;
    drain(100);

    // reset during the third pixel; held request redraws from the start
    @(negedge clk);
    set_params(0, 70, 80, 3, 2, 4);
    req = 4'b0001;
    t = int'(cyc);
    exp_pix(t+2, 70, 80, 4);
    exp_pix(t+3, 71, 80, 4);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midreset_plot", 64'(vga_plot), 64'd0);
    check("midreset_busy", 64'(busy),     64'd0);
    check("midreset_ack",  64'(ack),      64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    t = int'(cyc);
    exp_rect(t+2, 70, 80, 3, 2, 4);
    exp_ack(t+8, 0);
    drain(100);

    check("final_idle_busy", 64'(busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
